// File: rtl/gearbox_pkg.sv
// Shared gearbox definitions: gear codes, 7-segment patterns, shift thresholds.
// Used by the gearbox FSM, shift_commander and display checkers.
package gearbox_pkg;

  typedef enum logic [3:0] {
    GEAR_P   = 4'd0,
    GEAR_R   = 4'd1,
    GEAR_N   = 4'd2,
    GEAR_1   = 4'd3,
    GEAR_2   = 4'd4,
    GEAR_3   = 4'd5,
    GEAR_4   = 4'd6,
    GEAR_5   = 4'd7,
    GEAR_6   = 4'd8,
    GEAR_INV = 4'd15
  } gear_e;

  localparam logic [6:0] SEG_P = 7'b0111000;
  localparam logic [6:0] SEG_R = 7'b0101111;
  localparam logic [6:0] SEG_N = 7'b0111011;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_ACK,
    ST_HOLDOFF,
    ST_FAULT
  } cmd_state_e;

  // Upshift threshold (km/h) for a forward gear; saturates for gears with no upshift.
  function automatic logic [7:0] up_thr(input logic [3:0] g);
    case (g)
      GEAR_1:  up_thr = 8'd20;
      GEAR_2:  up_thr = 8'd40;
      GEAR_3:  up_thr = 8'd60;
      GEAR_4:  up_thr = 8'd80;
      GEAR_5:  up_thr = 8'd100;
      default: up_thr = 8'd255;
    endcase
  endfunction

  // Downshift threshold (km/h); zero for gears with no automatic downshift.
  function automatic logic [7:0] dn_thr(input logic [3:0] g);
    case (g)
      GEAR_2:  dn_thr = 8'd15;
      GEAR_3:  dn_thr = 8'd35;
      GEAR_4:  dn_thr = 8'd55;
      GEAR_5:  dn_thr = 8'd75;
      GEAR_6:  dn_thr = 8'd95;
      default: dn_thr = 8'd0;
    endcase
  endfunction

  function automatic logic can_up(input logic [3:0] g);
    can_up = (g >= GEAR_1) && (g <= GEAR_5);
  endfunction

  function automatic logic can_dn(input logic [3:0] g);
    can_dn = (g >= GEAR_2) && (g <= GEAR_6);
  endfunction

endpackage

// File: rtl/seg_gear_decoder.sv
// Combinational 7-segment display pattern to gear code decoder.
module seg_gear_decoder
  import gearbox_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] gear
);

  // Map each known display pattern back to its gear; anything else is invalid.
  always_comb begin
    case (seg)
      SEG_P:   gear = GEAR_P;
      SEG_R:   gear = GEAR_R;
      SEG_N:   gear = GEAR_N;
      SEG_1:   gear = GEAR_1;
      SEG_2:   gear = GEAR_2;
      SEG_3:   gear = GEAR_3;
      SEG_4:   gear = GEAR_4;
      SEG_5:   gear = GEAR_5;
      SEG_6:   gear = GEAR_6;
      default: gear = GEAR_INV;
    endcase
  end

endmodule

// File: rtl/shift_commander.sv
// Automatic shift command initiator: decodes the gearbox display, applies
// speed thresholds with hysteresis, pulses shift_up/shift_down, waits for the
// display to confirm, then holds off before the next decision.
// Optional feature: SHIFT_KICKDOWN_EN adds the kickdown input.
module shift_commander
  import gearbox_pkg::*;
#(
  parameter int SPEED_W        = 8,
  parameter int ACK_TIMEOUT    = 8,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         seg,
  input  logic [SPEED_W-1:0] speed,
  input  logic               auto_en,
  input  logic               drive_req,
`ifdef SHIFT_KICKDOWN_EN
  input  logic               kickdown,
`endif
  output logic               shift_up,
  output logic               shift_down,
  output logic [3:0]         gear,
  output logic               busy,
  output logic               fault
);

  localparam int CNT_MAX = (ACK_TIMEOUT > HOLDOFF_CYCLES) ? ACK_TIMEOUT : HOLDOFF_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  cmd_state_e       state, state_nxt;
  logic [3:0]       target;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             kd;
  logic             want_up, want_dn, kd_dn;
  logic             fire_up, fire_dn;

`ifdef SHIFT_KICKDOWN_EN
  assign kd = kickdown;
`else
  assign kd = 1'b0;
`endif

  seg_gear_decoder u_dec (
    .seg  (seg),
    .gear (gear)
  );

  assign cnt_inc = cnt + CNT_W'(1);

  // Shift decisions: up wins over down; kickdown blocks up and can force a down.
  always_comb begin
    want_up = auto_en && !kd &&
              ((gear == GEAR_N && drive_req) ||
               (can_up(gear) && speed > SPEED_W'(up_thr(gear))));
    want_dn = auto_en && can_dn(gear) && speed < SPEED_W'(dn_thr(gear));
    kd_dn   = auto_en && kd && can_dn(gear) &&
              speed <= SPEED_W'(up_thr(gear - 4'd1));
    fire_up = (state == ST_IDLE) && want_up;
    fire_dn = ((state == ST_IDLE) && !want_up && (want_dn || kd_dn)) ||
              ((state == ST_HOLDOFF) && kd_dn);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; dropping auto_en always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (fire_up || fire_dn) state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: if (gear == target) state_nxt = ST_HOLDOFF;
                   else if (cnt_inc == CNT_W'(ACK_TIMEOUT)) state_nxt = ST_FAULT;
      ST_HOLDOFF:  if (fire_dn) state_nxt = ST_WAIT_ACK;
                   else if (cnt <= CNT_W'(1)) state_nxt = ST_IDLE;
      ST_FAULT:    state_nxt = ST_FAULT;
      default:     state_nxt = ST_IDLE;
    endcase
    if (!auto_en) state_nxt = ST_IDLE;
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy  = (state == ST_WAIT_ACK) || (state == ST_HOLDOFF);
    fault = (state == ST_FAULT);
  end

  // Pulse registers, target latch and the shared ack/hold-off counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_up   <= 1'b0;
      shift_down <= 1'b0;
      target     <= 4'd0;
      cnt        <= '0;
    end else begin
      shift_up   <= fire_up;
      shift_down <= fire_dn;
      if (fire_up)      target <= gear + 4'd1;
      else if (fire_dn) target <= gear - 4'd1;
      if (!auto_en || fire_up || fire_dn)
        cnt <= '0;
      else if (state == ST_WAIT_ACK)
        cnt <= (gear == target) ? CNT_W'(HOLDOFF_CYCLES) : cnt_inc;
      else if (state == ST_HOLDOFF && cnt != '0)
        cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_shift_commander.sv
// Bench for shift_commander: table of single-decision vectors plus
// sequences against a small gearbox model driving seg from the pulses.
module tb_shift_commander;

  localparam logic [6:0] S_P = 7'b0111000;
  localparam logic [6:0] S_R = 7'b0101111;
  localparam logic [6:0] S_N = 7'b0111011;
  localparam logic [6:0] S_1 = 7'b0000110;
  localparam logic [6:0] S_2 = 7'b1011011;
  localparam logic [6:0] S_3 = 7'b1001111;
  localparam logic [6:0] S_4 = 7'b1100110;
  localparam logic [6:0] S_5 = 7'b1101101;
  localparam logic [6:0] S_6 = 7'b1111101;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg;
  logic [7:0] speed = 8'd0;
  logic       auto_en = 1'b0;
  logic       drive_req = 1'b0;
`ifdef SHIFT_KICKDOWN_EN
  logic       kickdown = 1'b0;
`endif
  logic       shift_up, shift_down, busy, fault;
  logic [3:0] gear;

  shift_commander dut (
    .clk        (clk),
    .reset      (reset),
    .seg        (seg),
    .speed      (speed),
    .auto_en    (auto_en),
    .drive_req  (drive_req),
`ifdef SHIFT_KICKDOWN_EN
    .kickdown   (kickdown),
`endif
    .shift_up   (shift_up),
    .shift_down (shift_down),
    .gear       (gear),
    .busy       (busy),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int g);
    case (g)
      0: seg_of = S_P;  1: seg_of = S_R;  2: seg_of = S_N;
      3: seg_of = S_1;  4: seg_of = S_2;  5: seg_of = S_3;
      6: seg_of = S_4;  7: seg_of = S_5;  8: seg_of = S_6;
      default: seg_of = 7'b0000000;
    endcase
  endfunction

  // Gearbox model: samples pulses on the edge, display updates after it.
  int         mgear = 2;
  int         mdl_init = 2;
  logic       mdl_en = 1'b0;
  logic       mdl_load = 1'b0;
  logic       raw_en = 1'b0;
  logic [6:0] seg_raw = 7'b0;

  always @(posedge clk) begin
    if (mdl_load) mgear <= mdl_init;
    else if (mdl_en) begin
      if (shift_up)        mgear <= mgear + 1;
      else if (shift_down) mgear <= mgear - 1;
    end
  end

  assign seg = raw_en ? seg_raw : seg_of(mgear);

  // Pulse monitor: records pulse cycles, checks exclusivity and width.
  int   cyc = 0;
  int   pcnt = 0;
  int   pcyc[$];
  logic pu_q = 1'b0, pd_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && (shift_up || shift_down)) begin
      pcnt = pcnt + 1;
      pcyc.push_back(cyc);
      chk("pulse_onehot", 32'(shift_up && shift_down), 0);
      chk("pulse_width", 32'((shift_up && pu_q) || (shift_down && pd_q)), 0);
    end
    pu_q <= shift_up;
    pd_q <= shift_down;
  end

  task automatic do_reset(input int g, input int spd, input logic ae, input logic dr, input logic me);
    @(negedge clk);
    reset = 1'b1;
    raw_en = 1'b0;
    mdl_en = me;
    mdl_init = g;
    mdl_load = 1'b1;
    speed = 8'(spd);
    auto_en = ae;
    drive_req = dr;
`ifdef SHIFT_KICKDOWN_EN
    kickdown = 1'b0;
`endif
    @(posedge clk);
    #1 mdl_load = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 80) begin
      @(posedge clk);
      #1 k++;
    end
    chk(name, 32'(busy), 0);
  endtask

  typedef struct {
    logic [6:0] seg;
    logic [7:0] speed;
    logic       ae;
    logic       dr;
    logic       up;
    logic       dn;
    logic [3:0] gear;
  } vec_t;

  vec_t vecs[21];

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p0, p1, early;

    vecs[0]  = '{S_N, 8'd0,   1, 1, 1, 0, 4'd2};
    vecs[1]  = '{S_N, 8'd0,   1, 0, 0, 0, 4'd2};
    vecs[2]  = '{S_1, 8'd21,  1, 0, 1, 0, 4'd3};
    vecs[3]  = '{S_1, 8'd20,  1, 0, 0, 0, 4'd3};
    vecs[4]  = '{S_1, 8'd0,   1, 0, 0, 0, 4'd3};
    vecs[5]  = '{S_2, 8'd16,  1, 0, 0, 0, 4'd4};
    vecs[6]  = '{S_2, 8'd14,  1, 0, 0, 1, 4'd4};
    vecs[7]  = '{S_2, 8'd41,  1, 0, 1, 0, 4'd4};
    vecs[8]  = '{S_3, 8'd61,  1, 0, 1, 0, 4'd5};
    vecs[9]  = '{S_3, 8'd34,  1, 0, 0, 1, 4'd5};
    vecs[10] = '{S_4, 8'd81,  1, 0, 1, 0, 4'd6};
    vecs[11] = '{S_5, 8'd101, 1, 0, 1, 0, 4'd7};
    vecs[12] = '{S_5, 8'd74,  1, 0, 0, 1, 4'd7};
    vecs[13] = '{S_6, 8'd255, 1, 0, 0, 0, 4'd8};
    vecs[14] = '{S_6, 8'd94,  1, 0, 0, 1, 4'd8};
    vecs[15] = '{S_6, 8'd95,  1, 0, 0, 0, 4'd8};
    vecs[16] = '{S_P, 8'd200, 1, 1, 0, 0, 4'd0};
    vecs[17] = '{S_R, 8'd200, 1, 1, 0, 0, 4'd1};
    vecs[18] = '{7'b0000000, 8'd200, 1, 1, 0, 0, 4'd15};
    vecs[19] = '{S_1, 8'd200, 0, 0, 0, 0, 4'd3};
    vecs[20] = '{S_4, 8'd60,  1, 0, 0, 0, 4'd6};

    // Reset state
    do_reset(2, 0, 0, 0, 0);
    #1;
    chk("rst_up", 32'(shift_up), 0);
    chk("rst_down", 32'(shift_down), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_gear", 32'(gear), 2);

    // Single-decision vectors, each from a fresh reset
    foreach (vecs[i]) begin
      do_reset(2, vecs[i].speed, vecs[i].ae, vecs[i].dr, 0);
      raw_en = 1'b1;
      seg_raw = vecs[i].seg;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_up", i), 32'(shift_up), 32'(vecs[i].up));
      chk($sformatf("vec%0d_dn", i), 32'(shift_down), 32'(vecs[i].dn));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].up | vecs[i].dn));
      chk($sformatf("vec%0d_gear", i), 32'(gear), 32'(vecs[i].gear));
    end

    // Engage from N: one-cycle pulse, 2 ack cycles + 16 hold-off cycles busy
    do_reset(2, 0, 1, 1, 1);
    @(posedge clk);
    #1;
    chk("engage_up", 32'(shift_up), 1);
    chk("engage_busy", 32'(busy), 1);
    drive_req = 1'b0;
    @(posedge clk);
    #1 chk("engage_up_drop", 32'(shift_up), 0);
    n = 2;
    while (busy && n < 60) begin
      @(posedge clk);
      #1 if (busy) n++;
    end
    chk("engage_busy_len", n, 18);
    chk("engage_gear", 32'(gear), 3);
    p0 = pcnt;
    repeat (5) @(posedge clk);
    #1 chk("engage_quiet", pcnt, p0);

    // Hysteresis G1 -> G2 -> G1
    do_reset(3, 21, 1, 0, 1);
    @(posedge clk);
    #1 chk("hyst_up", 32'(shift_up), 1);
    speed = 8'd20;
    wait_idle("hyst_idle1");
    chk("hyst_gear2", 32'(gear), 4);
    p0 = pcnt;
    repeat (4) @(posedge clk);
    #1 speed = 8'd16;
    repeat (4) @(posedge clk);
    #1 chk("hyst_band_quiet", pcnt, p0);
    speed = 8'd14;
    @(posedge clk);
    #1 chk("hyst_down", 32'(shift_down), 1);
    wait_idle("hyst_idle2");
    chk("hyst_gear1", 32'(gear), 3);
    p0 = pcnt;
    repeat (5) @(posedge clk);
    #1 chk("g1_no_auto_n", pcnt, p0);

    // Ack timeout: display stuck at G3
    do_reset(5, 70, 1, 0, 0);
    @(posedge clk);
    #1 chk("fault_up", 32'(shift_up), 1);
    early = 0;
    repeat (7) begin
      @(posedge clk);
      #1 if (fault || !busy) early++;
    end
    chk("fault_not_early", early, 0);
    @(posedge clk);
    #1;
    chk("fault_set", 32'(fault), 1);
    chk("fault_busy", 32'(busy), 0);
    p0 = pcnt;
    repeat (10) @(posedge clk);
    #1;
    chk("fault_no_pulse", pcnt, p0);
    chk("fault_held", 32'(fault), 1);
    auto_en = 1'b0;
    @(posedge clk);
    #1;
    chk("fault_clear", 32'(fault), 0);
    chk("fault_clear_busy", 32'(busy), 0);

    // Full climb at 200 km/h
    do_reset(3, 200, 1, 0, 1);
    p0 = pcnt;
    n = 0;
    while (gear != 4'd8 && n < 400) begin
      @(posedge clk);
      #1 n++;
    end
    repeat (60) @(posedge clk);
    #1 chk("climb_pulses", pcnt - p0, 5);
    for (int i = 1; i < 5; i++)
      if (p0 + i < pcyc.size())
        chk($sformatf("climb_spacing%0d", i), 32'((pcyc[p0+i] - pcyc[p0+i-1]) >= 19), 1);
    chk("climb_gear6", 32'(gear), 8);
    raw_en = 1'b1;
    seg_raw = 7'b0000000;
    p1 = pcnt;
    repeat (10) @(posedge clk);
    #1;
    chk("invalid_gear", 32'(gear), 15);
    chk("invalid_quiet", pcnt, p1);

    // Reset during a down pulse
    do_reset(4, 14, 1, 0, 0);
    @(posedge clk);
    #1 chk("midrst_pulse", 32'(shift_down), 1);
    reset = 1'b1;
    #1;
    chk("midrst_down0", 32'(shift_down), 0);
    chk("midrst_busy0", 32'(busy), 0);
    speed = 8'd30;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_idle_busy", 32'(busy), 0);
    chk("midrst_idle_up", 32'(shift_up | shift_down), 0);

    // G4 in hold-off, speed drops to 50
    do_reset(5, 61, 1, 0, 1);
    @(posedge clk);
    #1 chk("kd_up", 32'(shift_up), 1);
    speed = 8'd60;
    repeat (5) @(posedge clk);
    #1;
    chk("kd_holdoff_gear", 32'(gear), 6);
    chk("kd_holdoff_busy", 32'(busy), 1);
    speed = 8'd50;
`ifdef SHIFT_KICKDOWN_EN
    kickdown = 1'b1;
    @(posedge clk);
    #1 chk("kd_down", 32'(shift_down), 1);
    wait_idle("kd_idle");
    chk("kd_gear3", 32'(gear), 5);
`else
    @(posedge clk);
    #1 chk("holdoff_no_down", 32'(shift_down), 0);
    wait_idle("holdoff_idle");
    @(posedge clk);
    #1 chk("idle_down", 32'(shift_down), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
